axis_collector: RTL

//  Return-path counterpart of the PS->channel stream router: merges NUM_CH per-channel AXI-Stream

---
 rtl/axis_collector_if.sv | 32 +++
 rtl/axis_collector.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/axis_collector_if.sv
// AXI-Stream bundle linking the per-channel return sources, the collector and pl_to_ps.
// The master modport is the collector's view. The slave modport is the surrounding fabric.
interface axis_collector_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 256,
  parameter int ID_W   = 4
);
  logic [NUM_CH-1:0]        channel_enable;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic [ID_W-1:0]          m_axis_tuser;
  logic                     m_axis_tready;
  logic                     busy;
  logic [31:0]              pkt_count;

  modport master (
    input  channel_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           busy, pkt_count
  );

  modport slave (
    output channel_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           busy, pkt_count
  );
endinterface

// File: rtl/axis_collector.sv
// Merges NUM_CH channel streams into one stream toward the DMA path.
// Arbitration is round-robin and packet-atomic. The output is registered and tuser carries the source channel.
module axis_collector #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 256,
  parameter int ID_W   = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_collector_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [ID_W-1:0]   tuser_q, tuser_d;
  logic [31:0]       pkt_count_q, pkt_count_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] req_rot;
  logic              req_hit;
  logic [ID_W:0]     off_sel;
  logic [ID_W:0]     idx_sum;
  logic [ID_W-1:0]   req_idx;

  logic              out_ready;
  logic              accept;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_CH-1:0] s_tready;

  // Rotate requests so that bit 0 is the channel at rr_ptr. The first set bit is then the winner.
  assign req     = bus.s_axis_tvalid & bus.channel_enable;
  assign req_rot = (req >> rr_ptr_q) | (req << (NUM_CH - int'(rr_ptr_q)));

  always_comb begin
    req_hit = 1'b0;
    off_sel = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (!req_hit && req_rot[off]) begin
        req_hit = 1'b1;
        off_sel = (ID_W+1)'(off);
      end
    end
    idx_sum = {1'b0, rr_ptr_q} + off_sel;
    if (idx_sum >= (ID_W+1)'(NUM_CH)) begin
      idx_sum = idx_sum - (ID_W+1)'(NUM_CH);
    end
    req_idx = idx_sum[ID_W-1:0];
  end

  // Only the granted lane sees ready. That ready follows the output register's room, without a skid buffer.
  assign out_ready = !tvalid_q || bus.m_axis_tready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_tready  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == ID_W'(c)) begin
        sel_valid   = bus.s_axis_tvalid[c];
        sel_last    = bus.s_axis_tlast[c];
        sel_data    = bus.s_axis_tdata[c*DATA_W +: DATA_W];
        s_tready[c] = (state_q == ST_LOCK) && out_ready;
      end
    end
  end

  assign accept = (state_q == ST_LOCK) && sel_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hit) begin
          grant_d = req_idx;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (accept && sel_last) begin
          rr_ptr_d = (grant_q == ID_W'(NUM_CH-1)) ? '0 : grant_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register stage. A load wins over a drain, so a simultaneous drain and load presents the new beat.
  always_comb begin
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    pkt_count_d = pkt_count_q;
    if (accept) begin
      tdata_d  = sel_data;
      tlast_d  = sel_last;
      tuser_d  = grant_q;
      tvalid_d = 1'b1;
    end else if (bus.m_axis_tready) begin
      tvalid_d = 1'b0;
    end
    if (tvalid_q && bus.m_axis_tready && tlast_q && (pkt_count_q != 32'hFFFF_FFFF)) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign bus.busy          = (state_q == ST_LOCK);
  assign bus.pkt_count     = pkt_count_q;

endmodule
